// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM state, default latencies.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate family.
package mdu_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   localparam int unsigned MUL_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF = 10;
   localparam int unsigned CNT_W       = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic is_start_op(input logic [3:0] op);
      logic w_hit;
      w_hit = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
      w_hit = w_hit || (op == OP_MADD) || (op == OP_MADDU) ||
              (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return w_hit;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: produces the pending 64-bit {HI,LO} result for a mult/div op.
// MDU_MADD_EN adds the accumulate family; divide by zero returns the current {HI,LO}.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   output logic [63:0] o_res
);

   logic [63:0]        w_sprod;
   logic [63:0]        w_uprod;
   logic signed [31:0] w_squo;
   logic signed [31:0] w_srem;
   logic [31:0]        w_uquo;
   logic [31:0]        w_urem;
   logic               w_bzero;
   logic               w_ovf;

   // Sign-extending to 64 bits makes the low 64 bits of the unsigned product the signed product.
   assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
   assign w_uprod = {32'h0, i_a} * {32'h0, i_b};

   assign w_bzero = (i_b == '0);
   assign w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

   always_comb begin
      w_squo = '0;
      w_srem = '0;
      w_uquo = '0;
      w_urem = '0;
      if (!w_bzero && !w_ovf) begin
         w_squo = $signed(i_a) / $signed(i_b);
         w_srem = $signed(i_a) % $signed(i_b);
      end
      if (!w_bzero) begin
         w_uquo = i_a / i_b;
         w_urem = i_a % i_b;
      end
   end

   always_comb begin
      o_res = {i_hi, i_lo};
      case (i_op)
         OP_MULT:  o_res = w_sprod;
         OP_MULTU: o_res = w_uprod;
         OP_DIV: begin
            if (w_ovf)
               o_res = {32'h0, 32'h8000_0000};
            else if (!w_bzero)
               o_res = {w_srem, w_squo};
         end
         OP_DIVU: begin
            if (!w_bzero)
               o_res = {w_urem, w_uquo};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  o_res = {i_hi, i_lo} + w_sprod;
         OP_MADDU: o_res = {i_hi, i_lo} + w_uprod;
         OP_MSUB:  o_res = {i_hi, i_lo} - w_sprod;
         OP_MSUBU: o_res = {i_hi, i_lo} - w_uprod;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs one op at a fixed latency, drives D-stage stall.
// MDU_MADD_EN (via mdu_pkg/mdu_arith) enables MADD/MADDU/MSUB/MSUBU at MUL_LAT.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int unsigned MUL_LAT = MUL_LAT_DEF,
   parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_mdu,
   output logic        busy,
   output logic        stall,
   output logic [31:0] out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_phi;
   logic [31:0]        r_plo;

   logic [63:0]        w_res;
   logic               w_go;
   logic               w_mt;
   logic [CNT_W-1:0]   w_lat;

   mdu_arith u_arith (
      .i_op  (op),
      .i_a   (a),
      .i_b   (b),
      .i_hi  (r_hi),
      .i_lo  (r_lo),
      .o_res (w_res)
   );

   assign w_go  = start && !req && is_start_op(op);
   assign w_mt  = !req && ((op == OP_MTHI) || (op == OP_MTLO));
   assign w_lat = is_div_op(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_phi   <= '0;
         r_plo   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_phi   <= w_res[63:32];
                  r_plo   <= w_res[31:0];
                  r_cnt   <= w_lat;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end else if (w_mt) begin
                  if (op == OP_MTHI) r_hi <= a;
                  if (op == OP_MTLO) r_lo <= a;
               end
            end
            ST_RUN: begin
               // req and start are deliberately ignored here: a running op always commits.
               if (r_cnt <= CNT_W'(1)) begin
                  r_hi    <= r_phi;
                  r_lo    <= r_plo;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign stall = d_mdu && (r_busy || start);
   assign hi    = r_hi;
   assign lo    = r_lo;

   always_comb begin
      out = '0;
      if (op == OP_MFHI) out = r_hi;
      if (op == OP_MFLO) out = r_lo;
   end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with hand-computed HI/LO, busy and stall expectations.
// Build with +define+MDU_MADD_EN to exercise the accumulate family.
module tb_mdu_seq;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        req;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_mdu;
   logic        busy;
   logic        stall;
   logic [31:0] out;
   logic [31:0] hi;
   logic [31:0] lo;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;
   int unsigned ncyc;

   mdu_seq #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .d_mdu (d_mdu),
      .busy  (busy),
      .stall (stall),
      .out   (out),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
      start = 1'b1;
      op    = t_op;
      a     = t_a;
      b     = t_b;
      tick();
      start = 1'b0;
      op    = OP_NONE;
      a     = '0;
      b     = '0;
   endtask

   task automatic count_busy(output int unsigned n);
      n = 0;
      while (busy && n < 64) begin
         tick();
         n++;
      end
   endtask

   task automatic mt(input logic [3:0] t_op, input logic [31:0] t_a);
      op = t_op;
      a  = t_a;
      tick();
      op = OP_NONE;
      a  = '0;
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; start = 1'b0; op = OP_NONE;
      a = '0; b = '0; d_mdu = 1'b0;
      tick();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_stall", 32'(stall), 32'd0);
      #2 reset = 1'b1;
      tick();

      // MULT -2 * 3
      issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      count_busy(ncyc);
      check("mult_busy_cycles", 32'(ncyc), 32'd5);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);

      // DIV -7 / 2
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      count_busy(ncyc);
      check("div_busy_cycles", 32'(ncyc), 32'd10);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      // DIVU 7 / 0 keeps HI/LO
      issue(OP_DIVU, 32'd7, 32'd0);
      count_busy(ncyc);
      check("divz_busy_cycles", 32'(ncyc), 32'd10);
      check("divz_hi", hi, 32'hFFFF_FFFF);
      check("divz_lo", lo, 32'hFFFF_FFFD);

      // Signed overflow divide
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      count_busy(ncyc);
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'h0);

      // MULT cancelled by req
      req = 1'b1;
      issue(OP_MULT, 32'd9, 32'd9);
      req = 1'b0;
      check("req_start_busy", 32'(busy), 32'd0);
      tick();
      check("req_start_hi", hi, 32'h0);
      check("req_start_lo", lo, 32'h8000_0000);

      // req during cycle 3 and a stray start in cycle 2 must not disturb a running MULT
      issue(OP_MULT, 32'd5, 32'd7);
      ncyc = 0;
      while (busy && ncyc < 64) begin
         req   = (ncyc == 2);
         start = (ncyc == 1);
         op    = (ncyc == 1) ? OP_DIV : OP_NONE;
         a     = (ncyc == 1) ? 32'd1 : 32'd0;
         b     = (ncyc == 1) ? 32'd1 : 32'd0;
         tick();
         ncyc++;
      end
      req = 1'b0; start = 1'b0; op = OP_NONE; a = '0; b = '0;
      check("req_run_cycles", 32'(ncyc), 32'd5);
      check("req_run_lo", lo, 32'd35);
      check("req_run_hi", hi, 32'h0);

      // MTHI/MTLO then MFHI/MFLO
      mt(OP_MTHI, 32'h0000_ABCD);
      mt(OP_MTLO, 32'h0000_1234);
      op = OP_MFLO; #1;
      check("mflo_out", out, 32'h0000_1234);
      op = OP_MFHI; #1;
      check("mfhi_out", out, 32'h0000_ABCD);
      op = OP_NONE; #1;
      check("none_out", out, 32'h0);
      req = 1'b1;
      mt(OP_MTHI, 32'h0000_DEAD);
      req = 1'b0;
      check("mthi_req_hi", hi, 32'h0000_ABCD);

      // stall across a DIV with d_mdu held
      d_mdu = 1'b1;
      start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      #1;
      check("stall_cycle0", 32'(stall), 32'd1);
      tick();
      start = 1'b0; op = OP_NONE; a = '0; b = '0;
      #1;
      ncyc = 0;
      while (stall && ncyc < 64) begin
         tick();
         ncyc++;
      end
      check("stall_run_cycles", 32'(ncyc), 32'd10);
      check("stall_after", 32'(stall), 32'd0);
      check("div100_lo", lo, 32'd14);
      check("div100_hi", hi, 32'd2);
      d_mdu = 1'b0;

      // async reset during cycle 2 of a DIV
      issue(OP_DIV, 32'd100, 32'd7);
      tick();
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi", hi, 32'h0);
      check("arst_lo", lo, 32'h0);
      #2 reset = 1'b1;
      tick();
      tick();
      check("arst_idle_busy", 32'(busy), 32'd0);
      check("arst_idle_lo", lo, 32'h0);

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      count_busy(ncyc);
      check("multu_busy_cycles", 32'(ncyc), 32'd5);
      check("multu_hi", hi, 32'h1);
      check("multu_lo", lo, 32'hFFFF_FFFE);

      // accumulate family
      mt(OP_MTHI, 32'h0);
      mt(OP_MTLO, 32'hFFFF_FFFF);
      issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      count_busy(ncyc);
      check("maddu_busy_cycles", 32'(ncyc), 32'd5);
      check("maddu_hi", hi, 32'h1);
      check("maddu_lo", lo, 32'h0);
      issue(OP_MSUB, 32'd2, 32'd3);
      count_busy(ncyc);
      check("msub_hi", hi, 32'h0);
      check("msub_lo", lo, 32'hFFFF_FFFA);
`else
      check("maddu_off_busy", 32'(busy), 32'd0);
      tick();
      tick();
      check("maddu_off_hi", hi, 32'h0);
      check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
